// File: rtl/led_ctrl_pkg.sv
// Shared types and the mode-to-LED pattern mapping for the LED pattern controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  // top2 holds the two most significant step bits; top2[0] is the blink/alternate phase.
  function automatic logic [1:0] led_pattern(input mode_t mode, input logic [1:0] top2);
    logic [1:0] pat;
    pat = 2'b00;
    unique case (mode)
      MODE_OFF:   pat = 2'b00;
      MODE_COUNT: pat = top2;
      MODE_ALT:   pat = top2[0] ? 2'b10 : 2'b01;
      MODE_BLINK: pat = {top2[0], top2[0]};
      default:    pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler with a registered one-cycle tick on each wrap; pause freezes both.
module led_tick_gen #(
  parameter int unsigned PRESCALE_BITS = 13
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     pause,
  output logic [PRESCALE_BITS-1:0] prescaler,
  output logic                     tick
);

  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic                     tick_q, tick_d;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (!pause) begin
      presc_d = presc_q + PRESCALE_BITS'(1);
      tick_d  = (presc_q == '1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign prescaler = presc_q;
  assign tick      = tick_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Two-LED pattern controller: mode handshake, tick-aligned mode switching, step counter, LED map.
// Optional LED_PWM_EN adds a brightness input that gates the LEDs with a 16-phase PWM.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_BITS = 13,
  parameter int unsigned STEP_BITS     = 16
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [1:0] mode_req,
  input  logic       mode_valid,
  output logic       mode_ready,
  input  logic       pause,
`ifdef LED_PWM_EN
  input  logic [3:0] brightness,
`endif
  output logic       tick,
  output logic [1:0] cur_mode,
  output logic [1:0] LED
);

  logic [PRESCALE_BITS-1:0] prescaler;
  logic                     unused_prescaler;

  state_t                   state_q, state_d;
  mode_t                    cur_mode_q, cur_mode_d;
  mode_t                    pending_q, pending_d;
  logic [STEP_BITS-1:0]     step_q, step_d;
  logic                     handshake;
  logic                     apply;
  logic                     pwm_on;
  logic [1:0]               led_raw;

  led_tick_gen #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_tick_gen (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .pause    (pause),
    .prescaler(prescaler),
    .tick     (tick)
  );

  // Only the low PWM bits of the prescaler matter here; the rest just set the tick period.
  assign unused_prescaler = ^prescaler;

  assign handshake = mode_valid & mode_ready;
  assign apply     = (state_q == S_SWITCH) & tick;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF, S_RUN: begin
        if (handshake) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        if (tick) state_d = (pending_q == MODE_OFF) ? S_OFF : S_RUN;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    mode_ready = (state_q != S_SWITCH);
  end

  always_comb begin
    pending_d  = pending_q;
    cur_mode_d = cur_mode_q;
    step_d     = step_q;
    if (handshake) pending_d = mode_t'(mode_req);
    if (apply) begin
      cur_mode_d = pending_q;
      step_d     = '0;
    end else if ((state_q == S_RUN) && tick) begin
      step_d = step_q + STEP_BITS'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= MODE_OFF;
      cur_mode_q <= MODE_OFF;
      step_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      cur_mode_q <= cur_mode_d;
      step_q     <= step_d;
    end
  end

`ifdef LED_PWM_EN
  assign pwm_on = (prescaler[3:0] < brightness);
`else
  assign pwm_on = 1'b1;
`endif

  // During S_SWITCH cur_mode_q is untouched, so the old pattern stays on the LEDs.
  always_comb begin
    led_raw = led_pattern(cur_mode_q, step_q[STEP_BITS-1 -: 2]);
    LED     = led_raw & {2{pwm_on}};
  end

  assign cur_mode = cur_mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl with PRESCALE_BITS=4, STEP_BITS=4.
module tb_led_pattern_ctrl;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic [1:0] mode_req;
  logic       mode_valid;
  logic       mode_ready;
  logic       pause;
  logic       tick;
  logic [1:0] cur_mode;
  logic [1:0] LED;
`ifdef LED_PWM_EN
  logic [3:0] brightness;
`endif

  int checks = 0;
  int errors = 0;

  led_pattern_ctrl #(
    .PRESCALE_BITS(4),
    .STEP_BITS    (4)
  ) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .mode_req  (mode_req),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .pause     (pause),
`ifdef LED_PWM_EN
    .brightness(brightness),
`endif
    .tick      (tick),
    .cur_mode  (cur_mode),
    .LED       (LED)
  );

  always #5 CLK = ~CLK;

  task automatic wait_tick(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  first;
    bit  found;
    reset_n    = 1'b1;
    mode_req   = 2'd0;
    mode_valid = 1'b0;
    pause      = 1'b0;
`ifdef LED_PWM_EN
    brightness = 4'd0;
`endif
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (LED !== 2'b00 || cur_mode !== 2'd0 || mode_ready !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL por_outputs got led=%b mode=%0d rdy=%b tick=%b want 00/0/1/0",
               LED, cur_mode, mode_ready, tick);
    end
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    // bring up ALT so the LEDs are lit before the mid-run reset
    @(negedge CLK);
    mode_req   = 2'd2;
    mode_valid = 1'b1;
    @(negedge CLK);
    mode_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (cur_mode === 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_setup_alt got mode=%0d want 2 within 40 cycles", cur_mode);
    end
    checks++;
    if (LED !== 2'b01) begin
      errors++;
      $display("FAIL reset_setup_led got %b want 01", LED);
    end
    repeat (5) @(negedge CLK);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (LED !== 2'b00 || cur_mode !== 2'd0 || mode_ready !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got led=%b mode=%0d rdy=%b tick=%b want 00/0/1/0",
               LED, cur_mode, mode_ready, tick);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (tick === 1'b1) begin
        first = n;
        break;
      end
    end
    checks++;
    if (first != 16) begin
      errors++;
      $display("FAIL first_tick got cycle %0d want 16", first);
    end
  endtask

  task automatic test_mode_switch();
    logic [1:0] exp_count [0:7];
    exp_count = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    mode_req   = 2'd1;
    mode_valid = 1'b1;
    @(negedge CLK);
    mode_valid = 1'b0;
    checks++;
    if (mode_ready !== 1'b0 || cur_mode !== 2'd0) begin
      errors++;
      $display("FAIL switch_accept got rdy=%b mode=%0d want 0/0", mode_ready, cur_mode);
    end
    repeat (13) @(negedge CLK);
    checks++;
    if (tick !== 1'b1 || cur_mode !== 2'd0 || mode_ready !== 1'b0) begin
      errors++;
      $display("FAIL switch_tick got tick=%b mode=%0d rdy=%b want 1/0/0",
               tick, cur_mode, mode_ready);
    end
    @(negedge CLK);
    checks++;
    if (cur_mode !== 2'd1 || LED !== 2'b00 || mode_ready !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL switch_apply got mode=%0d led=%b rdy=%b tick=%b want 1/00/1/0",
               cur_mode, LED, mode_ready, tick);
    end
    for (int k = 1; k <= 8; k++) begin
      repeat (16) @(negedge CLK);
      checks++;
      if (LED !== exp_count[k-1]) begin
        errors++;
        $display("FAIL count_led step %0d got %b want %b", k, LED, exp_count[k-1]);
      end
    end
  endtask

  task automatic test_alt();
    logic [1:0] exp;
    mode_req   = 2'd2;
    mode_valid = 1'b1;
    @(negedge CLK);
    mode_valid = 1'b0;
    repeat (15) @(negedge CLK);
    checks++;
    if (cur_mode !== 2'd2) begin
      errors++;
      $display("FAIL alt_apply got mode=%0d want 2", cur_mode);
    end
    for (int j = 0; j < 32; j++) begin
      exp = ((j % 8) < 4) ? 2'b01 : 2'b10;
      checks++;
      if (LED !== exp) begin
        errors++;
        $display("FAIL alt_led tick %0d got %b want %b", j, LED, exp);
      end
      repeat (16) @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    wait_tick(40, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simul_wait got no tick want tick within 40 cycles");
    end
    // handshake lands in the tick cycle itself
    mode_req   = 2'd3;
    mode_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i == 5) mode_req = 2'd1;
      checks++;
      if (mode_ready !== 1'b0 || cur_mode !== 2'd2) begin
        errors++;
        $display("FAIL simul_hold cycle %0d got rdy=%b mode=%0d want 0/2",
                 i, mode_ready, cur_mode);
      end
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL simul_tick got %b want 1 16 cycles after accept", tick);
    end
    @(negedge CLK);
    checks++;
    if (cur_mode !== 2'd3 || mode_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_apply got mode=%0d rdy=%b want 3/1", cur_mode, mode_ready);
    end
    mode_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (mode_ready !== 1'b1 || cur_mode !== 2'd3 || LED !== 2'b00) begin
      errors++;
      $display("FAIL simul_single got rdy=%b mode=%0d led=%b want 1/3/00",
               mode_ready, cur_mode, LED);
    end
  endtask

  task automatic test_pause();
    bit found;
    int first;
    // four BLINK ticks bring step to 4, lighting both LEDs
    for (int t = 0; t < 4; t++) begin
      wait_tick(40, found);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL pause_wait %0d got no tick want tick within 40 cycles", t);
      end
    end
    @(negedge CLK);
    mode_req   = 2'd0;
    mode_valid = 1'b1;
    @(negedge CLK);
    mode_valid = 1'b0;
    pause      = 1'b1;
    checks++;
    if (mode_ready !== 1'b0 || LED !== 2'b11) begin
      errors++;
      $display("FAIL pause_enter got rdy=%b led=%b want 0/11", mode_ready, LED);
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      checks++;
      if (tick !== 1'b0 || mode_ready !== 1'b0 || cur_mode !== 2'd3 || LED !== 2'b11) begin
        errors++;
        $display("FAIL pause_hold cycle %0d got tick=%b rdy=%b mode=%0d led=%b want 0/0/3/11",
                 i, tick, mode_ready, cur_mode, LED);
      end
      if (i == 40) pause = 1'b0;
    end
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (tick === 1'b1) begin
        first = n;
        break;
      end
    end
    checks++;
    if (first != 14) begin
      errors++;
      $display("FAIL pause_resume_tick got cycle %0d want 14", first);
    end
    @(negedge CLK);
    checks++;
    if (cur_mode !== 2'd0 || LED !== 2'b00 || mode_ready !== 1'b1) begin
      errors++;
      $display("FAIL pause_apply got mode=%0d led=%b rdy=%b want 0/00/1",
               cur_mode, LED, mode_ready);
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    bit         found;
    int         lit;
    int         k;
    int         p;
    logic [1:0] exp;
    wait_tick(40, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pwm_wait got no tick want tick within 40 cycles");
    end
    brightness = 4'd4;
    @(negedge CLK);
    mode_req   = 2'd3;
    mode_valid = 1'b1;
    @(negedge CLK);
    mode_valid = 1'b0;
    repeat (14) @(negedge CLK);
    lit = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      k   = i / 16;
      p   = (17 + i) % 16;
      exp = (((k / 4) % 2) == 1 && p < 4) ? 2'b11 : 2'b00;
      if (LED === 2'b11) lit++;
      checks++;
      if (LED !== exp) begin
        errors++;
        $display("FAIL pwm_b4 cycle %0d got %b want %b", i, LED, exp);
      end
    end
    checks++;
    if (lit != 16) begin
      errors++;
      $display("FAIL pwm_b4_duty got %0d lit cycles want 16", lit);
    end
    brightness = 4'd0;
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      checks++;
      if (LED !== 2'b00) begin
        errors++;
        $display("FAIL pwm_b0 cycle %0d got %b want 00", i, LED);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mode_switch();
    test_alt();
    test_back_to_back();
    test_pause();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
